// File: rtl/io_input_sequencer.sv
// Switch-input instruction sequencer: stalls the PC while an input instruction
// waits for a debounced confirm press, captures the switches and issues a
// single register-file write pulse.
module io_input_sequencer #(
   parameter int unsigned DEBOUNCE_CYCLES = 16,
   parameter int unsigned SW_WIDTH        = 10,
   parameter int unsigned CNT_WIDTH       = 8
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 confirm_raw,
   input  logic                 in_req,
   input  logic [SW_WIDTH-1:0]  switches,
   output logic                 stall,
   output logic                 io_wr_en,
   output logic [31:0]          io_data,
   output logic                 press_pulse,
   output logic [2:0]           state_dbg,
   output logic [CNT_WIDTH-1:0] io_count
);

   localparam int unsigned DbW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [DbW-1:0] DbLast = DbW'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [2:0] {
      StIdle        = 3'd0,
      StWaitRelease = 3'd1,
      StWaitPress   = 3'd2,
      StCapture     = 3'd3,
      StDone        = 3'd4
   } state_t;

   logic [1:0]     sync_q;
   logic           level_q;
   logic           level_prev_q;
   logic [DbW-1:0] db_cnt_q;
   state_t         state_q;

   // Two-flop synchronizer for the asynchronous push-button level.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sync_q <= 2'b00;
      end else begin
         sync_q <= {sync_q[0], confirm_raw};
      end
   end

   // Debounce: the level only follows s2 after DEBOUNCE_CYCLES differing samples in a row.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         level_q  <= 1'b0;
         db_cnt_q <= '0;
      end else if (sync_q[1] != level_q) begin
         if (db_cnt_q == DbLast) begin
            level_q  <= sync_q[1];
            db_cnt_q <= '0;
         end else begin
            db_cnt_q <= db_cnt_q + 1'b1;
         end
      end else begin
         db_cnt_q <= '0;
      end
   end

   // Registered one-cycle pulse on each debounced rising edge.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         level_prev_q <= 1'b0;
         press_pulse  <= 1'b0;
      end else begin
         level_prev_q <= level_q;
         press_pulse  <= level_q & ~level_prev_q;
      end
   end

   // Transaction FSM with registered write pulse, data capture and counter.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q  <= StIdle;
         io_wr_en <= 1'b0;
         io_data  <= '0;
         io_count <= '0;
      end else begin
         io_wr_en <= 1'b0;
         case (state_q)
            StIdle: begin
               if (in_req) begin
                  // A button still held from the last input must be released first.
                  state_q <= level_q ? StWaitRelease : StWaitPress;
               end
            end
            StWaitRelease: begin
               if (!level_q) begin
                  state_q <= StWaitPress;
               end
            end
            StWaitPress: begin
               if (press_pulse) begin
                  state_q <= StCapture;
                  io_data <= 32'(switches);
               end
            end
            StCapture: begin
               // io_wr_en and io_count are set on entry so both are valid throughout DONE.
               state_q  <= StDone;
               io_wr_en <= 1'b1;
               io_count <= io_count + 1'b1;
            end
            StDone: begin
               state_q <= StIdle;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   // PC stall; forced low while reset is held so the reset state is fully quiet.
   always_comb begin
      stall = 1'b0;
      if (reset) begin
         case (state_q)
            StIdle:        stall = in_req;
            StWaitRelease: stall = 1'b1;
            StWaitPress:   stall = 1'b1;
            StCapture:     stall = 1'b1;
            default:       stall = 1'b0;
         endcase
      end
   end

   assign state_dbg = state_q;

endmodule

// File: tb/tb_io_input_sequencer.sv
// Directed bench for io_input_sequencer with DEBOUNCE_CYCLES=4.
module tb_io_input_sequencer;

   logic        clock;
   logic        reset;
   logic        confirm_raw;
   logic        in_req;
   logic [9:0]  switches;
   logic        stall;
   logic        io_wr_en;
   logic [31:0] io_data;
   logic        press_pulse;
   logic [2:0]  state_dbg;
   logic [7:0]  io_count;

   int passed = 0;
   int total  = 0;
   int wr_cnt = 0;
   int pulse_cnt = 0;
   int viol_cnt = 0;
   int timeouts = 0;

   typedef struct {
      int unsigned hold;
      int unsigned exp_pulses;
   } db_vec_t;

   db_vec_t vecs[6];

   io_input_sequencer #(
      .DEBOUNCE_CYCLES(4),
      .SW_WIDTH(10),
      .CNT_WIDTH(8)
   ) dut (
      .clock(clock),
      .reset(reset),
      .confirm_raw(confirm_raw),
      .in_req(in_req),
      .switches(switches),
      .stall(stall),
      .io_wr_en(io_wr_en),
      .io_data(io_data),
      .press_pulse(press_pulse),
      .state_dbg(state_dbg),
      .io_count(io_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Background monitors sampled on the falling edge.
   always @(negedge clock) begin
      if (reset && io_wr_en) wr_cnt++;
      if (reset && press_pulse) pulse_cnt++;
      if (io_wr_en && state_dbg != 3'd4) viol_cnt++;
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
      else passed++;
   endtask

   task automatic settle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   // Ticks until press_pulse is seen; n is the number of ticks taken (31 on timeout).
   task automatic wait_pulse(output int n);
      n = 31;
      for (int i = 1; i <= 30; i++) begin
         tick();
         if (press_pulse) begin
            n = i;
            break;
         end
      end
   endtask

   task automatic run_txn(input logic [9:0] sw);
      int n;
      bit ok;
      in_req = 1'b1;
      switches = sw;
      ok = 1'b0;
      for (int i = 0; i < 30; i++) begin
         tick();
         if (state_dbg == 3'd2) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) timeouts++;
      confirm_raw = 1'b1;
      wait_pulse(n);
      if (n > 30) timeouts++;
      confirm_raw = 1'b0;
      tick();
      tick();
      in_req = 1'b0;
      tick();
   endtask

   initial begin
      int n;
      int base;
      int hit;

      vecs[0] = '{hold: 1, exp_pulses: 0};
      vecs[1] = '{hold: 2, exp_pulses: 0};
      vecs[2] = '{hold: 3, exp_pulses: 0};
      vecs[3] = '{hold: 4, exp_pulses: 1};
      vecs[4] = '{hold: 5, exp_pulses: 1};
      vecs[5] = '{hold: 8, exp_pulses: 1};

      reset = 1'b0;
      confirm_raw = 1'b0;
      in_req = 1'b0;
      switches = '0;
      settle(2);
      check("rst_state", 32'(state_dbg), 0);
      check("rst_stall", 32'(stall), 0);
      check("rst_wr_en", 32'(io_wr_en), 0);
      check("rst_data", io_data, 0);
      check("rst_count", 32'(io_count), 0);
      check("rst_pulse", 32'(press_pulse), 0);
      reset = 1'b1;
      tick();

      // Scenario 1: basic transaction.
      in_req = 1'b1;
      switches = 10'h2A5;
      #1;
      check("s1_stall_idle", 32'(stall), 1);
      tick();
      check("s1_wait_press", 32'(state_dbg), 2);
      confirm_raw = 1'b1;
      for (int k = 1; k <= 7; k++) begin
         tick();
         if (k == 6) confirm_raw = 1'b0;
         check($sformatf("s1_pulse_k%0d", k), 32'(press_pulse), (k == 7) ? 1 : 0);
         check($sformatf("s1_state_k%0d", k), 32'(state_dbg), 2);
      end
      tick();
      check("s1_capture", 32'(state_dbg), 3);
      check("s1_capture_stall", 32'(stall), 1);
      check("s1_capture_data", io_data, 32'h2A5);
      tick();
      check("s1_done", 32'(state_dbg), 4);
      check("s1_done_wr", 32'(io_wr_en), 1);
      check("s1_done_stall", 32'(stall), 0);
      check("s1_done_data", io_data, 32'h0000_02A5);
      check("s1_done_count", 32'(io_count), 1);
      in_req = 1'b0;
      tick();
      check("s1_idle", 32'(state_dbg), 0);
      check("s1_idle_wr", 32'(io_wr_en), 0);
      check("s1_idle_count", 32'(io_count), 1);
      settle(12);

      // Scenario 2: short glitch while waiting for a press.
      in_req = 1'b1;
      tick();
      check("s2_wait_press", 32'(state_dbg), 2);
      base = pulse_cnt;
      confirm_raw = 1'b1;
      settle(3);
      confirm_raw = 1'b0;
      settle(12);
      check("s2_no_pulse", 32'(pulse_cnt - base), 0);
      check("s2_state", 32'(state_dbg), 2);
      check("s2_stall", 32'(stall), 1);

      // Scenario 3: button still held when the next input arrives.
      switches = 10'h155;
      confirm_raw = 1'b1;
      wait_pulse(n);
      check("s3_pulse_latency", 32'(n), 7);
      tick();
      check("s3_capture", 32'(state_dbg), 3);
      tick();
      check("s3_done_data", io_data, 32'h155);
      check("s3_done_count", 32'(io_count), 2);
      in_req = 1'b0;
      tick();
      check("s3_idle", 32'(state_dbg), 0);
      in_req = 1'b1;
      #1;
      check("s3_idle_stall", 32'(stall), 1);
      tick();
      check("s3_wait_release", 32'(state_dbg), 1);
      check("s3_wr_stall", 32'(stall), 1);
      settle(3);
      check("s3_still_release", 32'(state_dbg), 1);
      confirm_raw = 1'b0;
      n = 31;
      for (int i = 1; i <= 30; i++) begin
         tick();
         if (state_dbg == 3'd2) begin
            n = i;
            break;
         end
      end
      check("s3_release_latency", 32'(n), 7);
      switches = 10'h3FF;
      confirm_raw = 1'b1;
      wait_pulse(n);
      check("s3_press_latency", 32'(n), 7);
      confirm_raw = 1'b0;
      tick();
      tick();
      check("s3b_done", 32'(state_dbg), 4);
      check("s3b_done_wr", 32'(io_wr_en), 1);
      check("s3b_data", io_data, 32'h0000_03FF);
      check("s3b_count", 32'(io_count), 3);
      in_req = 1'b0;
      tick();
      settle(12);

      // Scenario 4: press in IDLE with no input instruction.
      switches = 10'h001;
      confirm_raw = 1'b1;
      wait_pulse(n);
      check("s4_latency", 32'(n), 7);
      check("s4_stall", 32'(stall), 0);
      check("s4_wr", 32'(io_wr_en), 0);
      check("s4_data", io_data, 32'h3FF);
      check("s4_count", 32'(io_count), 3);
      check("s4_state", 32'(state_dbg), 0);
      confirm_raw = 1'b0;
      tick();
      check("s4_pulse_one", 32'(press_pulse), 0);
      check("s4_state_after", 32'(state_dbg), 0);
      settle(12);

      // Debounce length table, applied in IDLE with no input instruction.
      for (int v = 0; v < 6; v++) begin
         base = pulse_cnt;
         confirm_raw = 1'b1;
         settle(int'(vecs[v].hold));
         confirm_raw = 1'b0;
         settle(20);
         check($sformatf("tbl_hold%0d_pulses", vecs[v].hold), 32'(pulse_cnt - base),
               32'(vecs[v].exp_pulses));
         check($sformatf("tbl_hold%0d_state", vecs[v].hold), 32'(state_dbg), 0);
      end

      // Scenario 5: asynchronous reset while in CAPTURE.
      in_req = 1'b1;
      switches = 10'h0AB;
      tick();
      check("s5_wait_press", 32'(state_dbg), 2);
      confirm_raw = 1'b1;
      wait_pulse(n);
      confirm_raw = 1'b0;
      tick();
      check("s5_capture", 32'(state_dbg), 3);
      check("s5_capture_data", io_data, 32'h0AB);
      #2;
      reset = 1'b0;
      #1;
      check("s5_rst_stall", 32'(stall), 0);
      check("s5_rst_wr", 32'(io_wr_en), 0);
      check("s5_rst_data", io_data, 0);
      check("s5_rst_count", 32'(io_count), 0);
      check("s5_rst_state", 32'(state_dbg), 0);
      tick();
      check("s5_rst_held_state", 32'(state_dbg), 0);
      reset = 1'b1;
      tick();
      check("s5_after_release", 32'(state_dbg), 2);

      // Scenario 6: counter wrap over 256 transactions.
      in_req = 1'b0;
      reset = 1'b0;
      tick();
      reset = 1'b1;
      tick();
      base = wr_cnt;
      hit = 0;
      for (int t = 1; t <= 256; t++) begin
         run_txn(10'(t));
         if (t == 255) check("s6_count_255", 32'(io_count), 255);
      end
      check("s6_count_wrap", 32'(io_count), 0);
      check("s6_last_data", io_data, 32'h100 & 32'h3FF);
      check("s6_wr_pulses", 32'(wr_cnt - base), 256);
      check("s6_timeouts", 32'(timeouts), 0);
      check("wr_only_in_done", 32'(viol_cnt), 32'(hit));

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
